// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with a glitch-free divisor update.
// Optional macro CLKDIV_SYNC_EN adds a `sync` input for phase-aligning dividers.
module clk_divider_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] eff_q, eff_d;
    logic [WIDTH:0]   half_d;
    logic             wrap;
    logic             apply;
    logic             sync_w;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    always_comb begin
        eff_q     = (div_q == '0) ? ONE : div_q;
        wrap      = (cnt_q >= (eff_q - ONE));
        apply     = 1'b0;
        cnt_d     = cnt_q;
        div_d     = div_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        tick_d    = 1'b0;

        if (sync_w) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            apply  = pending_q;
        end else if (!en) begin
            apply = pending_q;
            if (pending_q) begin
                cnt_d = '0;
            end
        end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            apply  = pending_q;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        // Apply uses the old pending value; a same-cycle load becomes the next one.
        if (apply) begin
            div_d     = pend_q;
            pending_d = 1'b0;
        end
        if (div_load) begin
            pend_d    = div_in;
            pending_d = 1'b1;
        end

        eff_d     = (div_d == '0) ? ONE : div_d;
        half_d    = ({1'b0, eff_d} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
        clk_out_d = ({1'b0, cnt_d} < half_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            div_q     <= DEF_DIV;
            pend_q    <= '0;
            pending_q <= 1'b0;
            clk_out_q <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule
